clk_ready_seq: RTL and testbench

Parametrised power-up and relock reset sequencer in the bus clock domain, replacing the fixed 16-bit hold-off counter used in top-level designs. It monitors NUM_LOCKS asynchronous PLL/MMCM lock inputs, glitch-filters them, and holds off for a programmed time once all are locked. It then releases NUM_STAGES active-high reset outputs in staggered order and re-sequences automatically on any lock loss or soft reset. Each stage output feeds the per-domain reset_sync instances.

---
 rtl/clk_ready_seq.sv | 199 +++++++++++++++++++
 tb/tb_clk_ready_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ready_seq.sv
// Power-up / relock reset sequencer: filters PLL lock inputs, waits a hold-off, then releases staged resets.
// Optional lock watchdog enabled by defining CLK_READY_SEQ_TIMEOUT_EN.
module clk_ready_seq #(
  parameter int unsigned NUM_LOCKS      = 2,
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned HOLDOFF_WIDTH  = 16,
  parameter int unsigned HOLDOFF_CYCLES = 65536,
  parameter int unsigned STAGE_GAP      = 256,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_LOCKS-1:0]  locked,
  input  logic                  soft_reset,
  input  logic                  clear_sticky,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  clocks_ready,
  output logic [1:0]            state,
  output logic [7:0]            relock_count,
  output logic                  lock_lost,
  output logic                  lock_timeout
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLDOFF   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned FILT_W   = $clog2(FILTER_LEN + 1);
  localparam int unsigned REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP;
  localparam int unsigned REL_W    = (REL_SPAN > 1) ? $clog2(REL_SPAN) : 1;

  localparam logic [FILT_W-1:0]        FILT_MAX  = FILT_W'(FILTER_LEN);
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_LAST = HOLDOFF_WIDTH'(HOLDOFF_CYCLES - 1);
  localparam logic [REL_W-1:0]         REL_LAST  = REL_W'((REL_SPAN == 0) ? 0 : REL_SPAN - 1);

  logic [NUM_LOCKS-1:0]  sync1, sync2, filter_ok;
  logic [FILT_W-1:0]     filt_cnt [NUM_LOCKS];
  logic                  lock_ok;

  state_t                state_q, state_d;
  logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic [REL_W-1:0]      rel_q, rel_d;
  logic [NUM_STAGES-1:0] stage_d;
  logic                  ready_d;
  logic                  loss_evt;

  // ---------------- input conditioning ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      lock_ok <= 1'b0;
      for (int unsigned i = 0; i < NUM_LOCKS; i++) filt_cnt[i] <= '0;
    end else begin
      sync1   <= locked;
      sync2   <= sync1;
      lock_ok <= &filter_ok;
      for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
        if (!sync2[i])
          filt_cnt[i] <= '0;
        else if (filt_cnt[i] != FILT_MAX)
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
      end
    end
  end

  // Qualifying with the live sample makes loss take effect one cycle ahead of the cleared count.
  always_comb begin
    filter_ok = '0;
    for (int unsigned i = 0; i < NUM_LOCKS; i++)
      filter_ok[i] = sync2[i] && (filt_cnt[i] == FILT_MAX);
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_LOCK;
      hold_q       <= '0;
      rel_q        <= '0;
      stage_rst    <= '1;
      clocks_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rel_q        <= rel_d;
      stage_rst    <= stage_d;
      clocks_ready <= ready_d;
    end
  end

  assign state    = state_q;
  assign loss_evt = (state_q == RUN) && !lock_ok;

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    unique case (state_q)
      WAIT_LOCK: begin
        hold_d = '0;
        rel_d  = '0;
        if (lock_ok) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (!lock_ok || soft_reset) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          rel_d  = '0;
          if (NUM_STAGES == 1) state_d = RUN;
          else                 state_d = RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_ok || soft_reset) begin
          state_d = WAIT_LOCK;
          rel_d   = '0;
        end else if (rel_q == REL_LAST) begin
          state_d = RUN;
          rel_d   = '0;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_ok || soft_reset) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // ---------------- outputs (registered from next state) ----------------
  always_comb begin
    stage_d = '1;
    ready_d = 1'b0;
    unique case (state_d)
      RELEASE: begin
        for (int unsigned k = 0; k < NUM_STAGES; k++)
          stage_d[k] = (32'(rel_d) < k * STAGE_GAP);
      end
      RUN: begin
        stage_d = '0;
        ready_d = 1'b1;
      end
      default: stage_d = '1;
    endcase
  end

  // ---------------- relock statistics ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      relock_count <= '0;
      lock_lost    <= 1'b0;
    end else begin
      if (loss_evt && relock_count != 8'hFF)
        relock_count <= relock_count + 1'b1;
      if (loss_evt)
        lock_lost <= 1'b1;
      else if (clear_sticky)
        lock_lost <= 1'b0;
    end
  end

`ifdef CLK_READY_SEQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_q;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;
  logic                     wd_hit;

  assign wd_inc = wd_q + 1'b1;
  assign wd_hit = (state_q == WAIT_LOCK) && (wd_q != '1) && (wd_inc == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q         <= '0;
      lock_timeout <= 1'b0;
    end else begin
      if (state_q != WAIT_LOCK)
        wd_q <= '0;
      else if (wd_q != '1)
        wd_q <= wd_inc;
      if (wd_hit)
        lock_timeout <= 1'b1;
      else if (clear_sticky)
        lock_timeout <= 1'b0;
    end
  end
`else
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clk_ready_seq.sv
// Scoreboard bench for clk_ready_seq: stimulus tasks push expected snapshots, each task drains and compares them.
module tb_clk_ready_seq;
  localparam int unsigned NL = 2, NS = 3, HW = 5, HC = 16, GAP = 4, FL = 3, TW = 6;
`ifdef CLK_READY_SEQ_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0, soft_reset = 1'b0, clear_sticky = 1'b0;
  logic [NL-1:0] locked = '0;
  logic [NS-1:0] stage_rst;
  logic          clocks_ready, lock_lost, lock_timeout;
  logic [1:0]    state;
  logic [7:0]    relock_count;

  clk_ready_seq #(
    .NUM_LOCKS(NL), .NUM_STAGES(NS), .HOLDOFF_WIDTH(HW), .HOLDOFF_CYCLES(HC),
    .STAGE_GAP(GAP), .FILTER_LEN(FL), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .locked(locked), .soft_reset(soft_reset),
    .clear_sticky(clear_sticky), .stage_rst(stage_rst), .clocks_ready(clocks_ready),
    .state(state), .relock_count(relock_count), .lock_lost(lock_lost), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   at;
    logic [95:0]   tag;
    logic [NS-1:0] srst;
    logic          rdy;
    logic [1:0]    st;
    logic [7:0]    rc;
    logic          lost;
    logic          chk_to;
    logic          to;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0, passed = 0;
  logic [7:0]  m_rc = '0;
  logic        m_lost = 1'b0;
  bit          stim_done;

  task automatic tick(int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_to(int unsigned t);
    while (cyc < t) tick(1);
  endtask

  function automatic void push(int unsigned at, logic [95:0] tag, logic [NS-1:0] srst,
                               logic rdy, logic [1:0] st, logic chk_to = 1'b0, logic to = 1'b0);
    exp_t e;
    e.at = at; e.tag = tag; e.srst = srst; e.rdy = rdy; e.st = st;
    e.rc = m_rc; e.lost = m_lost; e.chk_to = chk_to; e.to = to;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    exp_t e;
    stim_done = 0;
    fork
      begin
        push(cyc + 1, "reset", 3'b111, 1'b0, 2'd0, 1'b1, 1'b0);
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost || (e.chk_to && lock_timeout !== e.to))
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b to=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b to=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost, lock_timeout,
                       e.srst, e.rdy, e.st, e.rc, e.lost, e.to);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_timeout();
    exp_t e;
    int unsigned c;
    stim_done = 0;
    fork
      begin
        c = cyc;
        reset_n = 1'b1;
        push(c + 62, "wd_pre", 3'b111, 1'b0, 2'd0, 1'b1, 1'b0);
        push(c + 63, "wd_hit", 3'b111, 1'b0, 2'd0, 1'b1, TO_EXP);
        push(c + 70, "wd_hold", 3'b111, 1'b0, 2'd0, 1'b1, TO_EXP);
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost || (e.chk_to && lock_timeout !== e.to))
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b to=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b to=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost, lock_timeout,
                       e.srst, e.rdy, e.st, e.rc, e.lost, e.to);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_glitch();
    exp_t e;
    stim_done = 0;
    fork
      begin
        locked[0] = 1'b1;
        for (int i = 0; i < 51; i++) begin
          locked[1] = ((i % 3) != 2);
          push(cyc + 1, "glitch", 3'b111, 1'b0, 2'd0);
          tick(1);
        end
        locked = '0;
        tick(5);
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost)
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost,
                       e.srst, e.rdy, e.st, e.rc, e.lost);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_holdoff_abort();
    exp_t e;
    int unsigned r0, r1;
    stim_done = 0;
    fork
      begin
        locked = '0;
        tick(5);
        r0 = cyc + 1;
        locked = '1;
        push(r0 + 5,  "ho_wait", 3'b111, 1'b0, 2'd0);
        push(r0 + 6,  "ho_enter", 3'b111, 1'b0, 2'd1);
        wait_to(r0 + 15);
        locked[1] = 1'b0;              // sampled on the edge holdoff reaches 10
        push(r0 + 18, "ho_pre", 3'b111, 1'b0, 2'd1);
        push(r0 + 19, "ho_abort", 3'b111, 1'b0, 2'd0);
        wait_to(r0 + 21);
        r1 = cyc + 1;
        locked[1] = 1'b1;
        push(r1 + 21, "ho_full", 3'b111, 1'b0, 2'd1);
        push(r1 + 22, "ho_rel", 3'b110, 1'b0, 2'd2);
        wait_to(r1 + 23);
        locked = '0;
        push(r1 + 26, "rel_pre", 3'b100, 1'b0, 2'd2);
        push(r1 + 27, "rel_abort", 3'b111, 1'b0, 2'd0);
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost)
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost,
                       e.srst, e.rdy, e.st, e.rc, e.lost);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_powerup();
    exp_t e;
    int unsigned e0;
    stim_done = 0;
    fork
      begin
        locked = '0;
        tick(5);
        e0 = cyc + 1;
        locked = '1;
        push(e0 + 5,  "pu_wait", 3'b111, 1'b0, 2'd0);
        push(e0 + 6,  "pu_hold", 3'b111, 1'b0, 2'd1);
        push(e0 + 21, "pu_hold_end", 3'b111, 1'b0, 2'd1);
        push(e0 + 22, "pu_stage0", 3'b110, 1'b0, 2'd2);
        push(e0 + 25, "pu_pre1", 3'b110, 1'b0, 2'd2);
        push(e0 + 26, "pu_stage1", 3'b100, 1'b0, 2'd2);
        push(e0 + 29, "pu_pre2", 3'b100, 1'b0, 2'd2);
        push(e0 + 30, "pu_run", 3'b000, 1'b1, 2'd3);
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost)
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost,
                       e.srst, e.rdy, e.st, e.rc, e.lost);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_lock_loss();
    exp_t e;
    int unsigned d0, r0;
    stim_done = 0;
    fork
      begin
        tick(3);
        d0 = cyc + 1;
        locked[0] = 1'b0;
        push(d0 + 2, "loss_pre", 3'b000, 1'b1, 2'd3);
        m_rc   = m_rc + 8'd1;
        m_lost = 1'b1;
        push(d0 + 3, "loss", 3'b111, 1'b0, 2'd0);
        wait_to(d0 + 5);
        r0 = cyc + 1;
        locked[0] = 1'b1;
        push(r0 + 29, "relock_pre", 3'b100, 1'b0, 2'd2);
        push(r0 + 30, "relock_run", 3'b000, 1'b1, 2'd3);
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost)
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost,
                       e.srst, e.rdy, e.st, e.rc, e.lost);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_soft_sticky();
    exp_t e;
    int unsigned c, d0;
    stim_done = 0;
    fork
      begin
        c = cyc;
        soft_reset = 1'b1;
        push(c + 1,  "soft", 3'b111, 1'b0, 2'd0);
        push(c + 2,  "soft_reseq", 3'b111, 1'b0, 2'd1);
        push(c + 26, "soft_run", 3'b000, 1'b1, 2'd3);
        tick(1);
        soft_reset = 1'b0;
        wait_to(c + 28);
        d0 = cyc + 1;
        locked[1] = 1'b0;
        wait_to(d0 + 2);
        clear_sticky = 1'b1;           // coincides with the loss event edge
        m_rc   = m_rc + 8'd1;
        m_lost = 1'b1;
        push(d0 + 3, "clr_vs_set", 3'b111, 1'b0, 2'd0);
        tick(1);
        clear_sticky = 1'b0;
        wait_to(d0 + 5);
        clear_sticky = 1'b1;
        m_lost = 1'b0;
        push(d0 + 6, "clr_only", 3'b111, 1'b0, 2'd0);
        tick(1);
        clear_sticky = 1'b0;
        stim_done = 1;
      end
      begin
        while (!stim_done || exp_q.size() != 0) begin
          if (exp_q.size() == 0) tick(1);
          else begin
            e = exp_q.pop_front();
            wait_to(e.at);
            checks++;
            if (cyc != e.at || stage_rst !== e.srst || clocks_ready !== e.rdy || state !== e.st ||
                relock_count !== e.rc || lock_lost !== e.lost)
              $display("FAIL %0s cyc=%0d got srst=%b rdy=%b st=%0d rc=%0d lost=%b want srst=%b rdy=%b st=%0d rc=%0d lost=%b",
                       e.tag, cyc, stage_rst, clocks_ready, state, relock_count, lock_lost,
                       e.srst, e.rdy, e.st, e.rc, e.lost);
            else passed++;
          end
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d required completion before 200000 ns", cyc);
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    tick(2);
    test_reset();
    test_timeout();
    test_glitch();
    test_holdoff_abort();
    test_powerup();
    test_lock_loss();
    test_soft_sticky();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
